// File: rtl/issue_scoreboard.sv
// issue_scoreboard
// Sits between decode and execute. Keeps a small pending-write counter for
// every architectural register, stalls decode on read-after-write hazards
// (and when a destination already has the maximum number of writes in
// flight), and hands hazard-free instructions to execute through a
// registered valid stage.
//
// Ports:
//   clk           core clock, rising edge
//   rst           synchronous reset, active-high
//   dec_valid     decode holds a valid instruction
//   dec_instr     instruction in decode
//   dec_ready     combinational accept indication back to decode
//   issue_valid   registered: execute-stage instruction valid
//   issue_instr   registered: instruction issued to execute (NOP when idle)
//   wb_valid      writeback retires a register write this cycle
//   wb_rd         destination register of the retiring write
//   flush         redirect: drop the decode instruction this cycle
//   inflight      registered: total outstanding tracked writes
//   stall_cycles  registered: saturating count of hazard-stall cycles
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_valid,
  input  logic [31:0]            dec_instr,
  output logic                   dec_ready,
  output logic                   issue_valid,
  output logic [31:0]            issue_instr,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  input  logic                   flush,
  output logic [5:0]             inflight,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [31:0]      NOP     = 32'h0000_0013;

  logic [CNT_W-1:0] pend [0:31];

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       writes_rd;
  logic       use_rs1;
  logic       use_rs2;
  logic       hazard;
  logic       accept;
  logic       stall_evt;
  logic [31:0] inc_vec;
  logic [31:0] dec_vec;
  logic       inc_any;
  logic       dec_any;

  // Field extraction and per-opcode source/destination usage. Unknown
  // opcodes neither read nor write registers and pass through as bubbles.
  always_comb begin
    opcode    = dec_instr[6:0];
    rd        = dec_instr[11:7];
    rs1       = dec_instr[19:15];
    rs2       = dec_instr[24:20];
    writes_rd = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (opcode)
      7'b0110011: begin writes_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b0010011,
      7'b0000011: begin writes_rd = 1'b1; use_rs1 = 1'b1; end
      7'b0110111,
      7'b1101111: begin writes_rd = 1'b1; end
      7'b0100011,
      7'b1100011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      default:    begin end
    endcase
  end

  // Hazard detection looks only at the registered counters, so a write
  // retiring this very cycle still blocks its consumer (no bypass).
  // x0 is excluded on both the read and the write side.
  always_comb begin
    hazard = 1'b0;
    if (use_rs1 && rs1 != 5'd0 && pend[rs1] != '0) hazard = 1'b1;
    if (use_rs2 && rs2 != 5'd0 && pend[rs2] != '0) hazard = 1'b1;
    if (writes_rd && rd != 5'd0 && pend[rd] == MAX_CNT) hazard = 1'b1;
  end

  assign dec_ready = !hazard || !dec_valid;
  assign accept    = dec_valid && !hazard && !flush;
  assign stall_evt = dec_valid && hazard && !flush;

  // One-hot increment/decrement requests per register. Bit 0 stays clear so
  // x0 is never counted; retirements to an idle register are ignored.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < 32; r++) begin
      inc_vec[r] = accept && writes_rd && (rd == 5'(r));
      dec_vec[r] = wb_valid && (wb_rd == 5'(r)) && (pend[r] != '0);
    end
    inc_any = |inc_vec;
    dec_any = |dec_vec;
  end

  // Pending counters: simultaneous issue and retire on the same register
  // cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) pend[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          pend[r] <= pend[r] + 1'b1;
        else if (dec_vec[r] && !inc_vec[r])
          pend[r] <= pend[r] - 1'b1;
      end
    end
  end

  // Issue register, in-flight total and the saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid  <= 1'b0;
      issue_instr  <= '0;
      inflight     <= '0;
      stall_cycles <= '0;
    end else begin
      issue_valid <= accept;
      issue_instr <= accept ? dec_instr : NOP;
      case ({inc_any, dec_any})
        2'b10:   inflight <= inflight + 6'd1;
        2'b01:   inflight <= inflight - 6'd1;
        default: inflight <= inflight;
      endcase
      if (stall_evt && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard
// Directed-vector bench for issue_scoreboard. Inputs are driven 1 time unit
// after the rising edge; combinational dec_ready is sampled 1 unit later and
// registered outputs are sampled 1 unit after the following rising edge.
module tb_issue_scoreboard;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic        dec_ready;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [5:0]  inflight;
  logic [15:0] stall_cycles;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [54:0] obs;
  logic [54:0] want;
  assign obs = {issue_valid, issue_instr, inflight, stall_cycles};

  issue_scoreboard #(
    .MAX_INFLIGHT(3),
    .CNT_W(2),
    .STALL_CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dec_valid(dec_valid),
    .dec_instr(dec_instr),
    .dec_ready(dec_ready),
    .issue_valid(issue_valid),
    .issue_instr(issue_instr),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .flush(flush),
    .inflight(inflight),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; dec_valid = 1'b0; dec_instr = '0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    tick; tick;
    rst = 1'b0;
    #1;
    want = {1'b0, 32'h0, 6'd0, 16'd0};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL reset_state: got %h want %h", obs, want); end
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b want 1", dec_ready); end
  endtask

  task automatic test_raw;
    dec_valid = 1'b1; dec_instr = 32'h002081B3;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_first_ready: got %b want 1", dec_ready); end
    tick;
    want = {1'b1, 32'h002081B3, 6'd1, 16'd0};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL raw_first_issue: got %h want %h", obs, want); end
    dec_instr = 32'h00118233;
    for (int i = 1; i <= 2; i++) begin
      #1;
      n_cmp++;
      if (dec_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_stall_ready%0d: got %b want 0", i, dec_ready); end
      tick;
      want = {1'b0, NOP, 6'd1, 16'(i)};
      n_cmp++;
      if (obs !== want) begin n_fail++; $display("[TB] FAIL raw_stall%0d: got %h want %h", i, obs, want); end
    end
    wb_valid = 1'b1; wb_rd = 5'd3;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL raw_wb_cycle_ready: got %b want 0", dec_ready); end
    tick;
    want = {1'b0, NOP, 6'd0, 16'd3};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL raw_wb_cycle: got %h want %h", obs, want); end
    wb_valid = 1'b0;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL raw_release_ready: got %b want 1", dec_ready); end
    tick;
    want = {1'b1, 32'h00118233, 6'd1, 16'd3};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL raw_release_issue: got %h want %h", obs, want); end
    dec_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd4;
    tick;
    wb_valid = 1'b0;
    want = {1'b0, NOP, 6'd0, 16'd3};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL raw_drain: got %h want %h", obs, want); end
  endtask

  task automatic test_x0;
    dec_valid = 1'b1; dec_instr = 32'h00500013;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL x0_write_ready: got %b want 1", dec_ready); end
    tick;
    want = {1'b1, 32'h00500013, 6'd0, 16'd3};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL x0_write_uncounted: got %h want %h", obs, want); end
    dec_instr = 32'h000002B3;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL x0_read_ready: got %b want 1", dec_ready); end
    tick;
    want = {1'b1, 32'h000002B3, 6'd1, 16'd3};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL x0_read_issue: got %h want %h", obs, want); end
    dec_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd5;
    tick;
    wb_valid = 1'b0;
    want = {1'b0, NOP, 6'd0, 16'd3};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL x0_drain: got %h want %h", obs, want); end
  endtask

  task automatic test_saturation;
    dec_valid = 1'b1; dec_instr = 32'h00100393;
    for (int i = 1; i <= 3; i++) begin
      #1;
      n_cmp++;
      if (dec_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_fill_ready%0d: got %b want 1", i, dec_ready); end
      tick;
      want = {1'b1, 32'h00100393, 6'(i), 16'd3};
      n_cmp++;
      if (obs !== want) begin n_fail++; $display("[TB] FAIL sat_fill%0d: got %h want %h", i, obs, want); end
    end
    #1;
    n_cmp++;
    if (dec_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_full_ready: got %b want 0", dec_ready); end
    tick;
    want = {1'b0, NOP, 6'd3, 16'd4};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL sat_full_stall: got %h want %h", obs, want); end
    wb_valid = 1'b1; wb_rd = 5'd7;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_wb_ready: got %b want 0", dec_ready); end
    tick;
    wb_valid = 1'b0;
    want = {1'b0, NOP, 6'd2, 16'd5};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL sat_wb_cycle: got %h want %h", obs, want); end
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_release_ready: got %b want 1", dec_ready); end
    tick;
    want = {1'b1, 32'h00100393, 6'd3, 16'd5};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL sat_release_issue: got %h want %h", obs, want); end
    dec_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd7;
    tick; tick; tick;
    wb_valid = 1'b0;
    want = {1'b0, NOP, 6'd0, 16'd5};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL sat_drain: got %h want %h", obs, want); end
  endtask

  task automatic test_flush;
    dec_valid = 1'b1; dec_instr = 32'h00100413;
    tick;
    want = {1'b1, 32'h00100413, 6'd1, 16'd5};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL flush_pre_issue: got %h want %h", obs, want); end
    flush = 1'b1; dec_instr = 32'h00100493;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_ready: got %b want 1", dec_ready); end
    tick;
    want = {1'b0, NOP, 6'd1, 16'd5};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL flush_drop: got %h want %h", obs, want); end
    flush = 1'b0; dec_instr = 32'h00948533;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_x9_clear_ready: got %b want 1", dec_ready); end
    tick;
    want = {1'b1, 32'h00948533, 6'd2, 16'd5};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL flush_x9_clear_issue: got %h want %h", obs, want); end
    dec_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd8;
    tick;
    want = {1'b0, NOP, 6'd1, 16'd5};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL flush_x8_retire: got %h want %h", obs, want); end
    wb_rd = 5'd10;
    tick;
    wb_valid = 1'b0;
    dec_valid = 1'b1; dec_instr = 32'h00100413;
    tick;
    dec_instr = 32'h00040533; flush = 1'b1;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_hazard_ready: got %b want 0", dec_ready); end
    tick;
    want = {1'b0, NOP, 6'd1, 16'd5};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL flush_hazard_nocount: got %h want %h", obs, want); end
    flush = 1'b0; dec_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd8;
    tick;
    wb_valid = 1'b0;
    want = {1'b0, NOP, 6'd0, 16'd5};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL flush_drain: got %h want %h", obs, want); end
  endtask

  task automatic test_simultaneous;
    dec_valid = 1'b1; dec_instr = 32'h00100313;
    tick;
    wb_valid = 1'b1; wb_rd = 5'd6;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL simul_ready: got %b want 1", dec_ready); end
    tick;
    want = {1'b1, 32'h00100313, 6'd1, 16'd5};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL simul_issue_retire: got %h want %h", obs, want); end
    dec_valid = 1'b0; wb_rd = 5'd12;
    tick;
    want = {1'b0, NOP, 6'd1, 16'd5};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL spurious_wb12: got %h want %h", obs, want); end
    wb_rd = 5'd0;
    tick;
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL spurious_wb0: got %h want %h", obs, want); end
    wb_valid = 1'b0; dec_valid = 1'b1; dec_instr = 32'h000305B3;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL simul_x6_pending_ready: got %b want 0", dec_ready); end
    tick;
    want = {1'b0, NOP, 6'd1, 16'd6};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL simul_x6_stall: got %h want %h", obs, want); end
    wb_valid = 1'b1; wb_rd = 5'd6;
    tick;
    wb_valid = 1'b0;
    tick;
    want = {1'b1, 32'h000305B3, 6'd1, 16'd7};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL simul_x6_release: got %h want %h", obs, want); end
    dec_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd11;
    tick;
    wb_valid = 1'b0;
    want = {1'b0, NOP, 6'd0, 16'd7};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL simul_drain: got %h want %h", obs, want); end
  endtask

  task automatic test_bubble_and_reset;
    dec_valid = 1'b1; dec_instr = 32'h0000000F;
    tick;
    want = {1'b1, 32'h0000000F, 6'd0, 16'd7};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL bubble_issue: got %h want %h", obs, want); end
    dec_instr = 32'h00100393;
    tick;
    dec_valid = 1'b0; rst = 1'b1;
    tick;
    rst = 1'b0;
    want = {1'b0, 32'h0, 6'd0, 16'd0};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL midop_reset: got %h want %h", obs, want); end
    wb_valid = 1'b1; wb_rd = 5'd7;
    tick;
    wb_valid = 1'b0;
    want = {1'b0, NOP, 6'd0, 16'd0};
    n_cmp++;
    if (obs !== want) begin n_fail++; $display("[TB] FAIL post_reset_wb: got %h want %h", obs, want); end
  endtask

  initial begin
    test_reset;
    test_raw;
    test_x0;
    test_saturation;
    test_flush;
    test_simultaneous;
    test_bubble_and_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
